pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Handles load-use stalls, multi-cycle mul/div occupancy of EX, taken-branch squashing and data-memory wait states, and keeps stall statistics plus a memory-timeout flag.

Parameters:
REG_BITS, 5, register-specifier width
MULDIV_CYCLES, 4, total EX occupancy of a mul/div, ≥1
MEM_TIMEOUT, 16, consecutive MemReady-low cycles before MemTimeout sets
CNT_W, 16, StallCycles counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
IFID_Rs  in  REG_BITS  rs of instruction in ID
IFID_Rt  in  REG_BITS  rt of instruction in ID
IFID_UsesRt  in  1  ID instruction reads rt
IDEX_MemRead  in  1  EX instruction is a load
IDEX_Rt  in  REG_BITS  load destination in EX
IDEX_MulDiv  in  1  EX instruction is mul/div
BranchTaken_EX  in  1  branch in EX resolved taken
EXMEM_MemAccess  in  1  MEM instruction accesses data memory
MemReady  in  1  data memory ready this cycle
PC_Enable  out  1  PC load enable
IFID_Enable  out  1  IF/ID enable
IFID_Flush  out  1  zero IF/ID contents on load
IDEX_Enable  out  1  ID/EX enable
IDEX_Flush  out  1  load bubble into ID/EX
EXMEM_Enable  out  1  EX/MEM enable
EXMEM_Flush  out  1  load bubble into EX/MEM
MEMWB_Enable  out  1  MEM/WB enable
MEMWB_Flush  out  1  load bubble into MEM/WB
MemTimeout  out  1  sticky timeout flag
StallCycles  out  CNT_W  saturating count of cycles with PC_Enable=0
State  out  1  0=RUN, 1=MULDIV

Behaviour:
- Control outputs are combinational from state, counter and inputs; zero extra latency.
- While reset=1: all enables 0, all flushes 0.
- Registered state on reset: State=RUN, mul/div counter=0, MemTimeout=0, StallCycles=0, wait counter=0.
- Default (RUN, no event): all enables 1, all flushes 0.
- Conditions:
  - memwait = EXMEM_MemAccess & ~MemReady
  - loaduse = IDEX_MemRead & (IDEX_Rt≠0) & (IFID_Rs==IDEX_Rt | (IFID_UsesRt & IFID_Rt==IDEX_Rt))
- Priority, highest first: reset > memwait > mul/div stall > branch > loaduse > run.
- memwait: PC/IFID/IDEX/EXMEM enables 0, MEMWB_Enable=1, MEMWB_Flush=1. State and mul/div counter hold.
- Mul/div trigger: in RUN with IDEX_MulDiv=1 and MULDIV_CYCLES>1.
  - Outputs: PC/IFID/IDEX enables 0, EXMEM_Flush=1, MEMWB_Enable=1.
  - Counter loads MULDIV_CYCLES-1; next State=MULDIV.
- MULDIV state, counter>1: same stall outputs, counter decrements.
- MULDIV state, counter==1: release. Normal RUN outputs, with branch and loaduse still evaluated. Next State=RUN, counter=0. IDEX_MulDiv is ignored in this cycle, so there is no retrigger.
- MULDIV_CYCLES=1: a mul/div never stalls.
- Branch (BranchTaken_EX, RUN or release cycle): all enables 1, IFID_Flush=1, IDEX_Flush=1. This overrides loaduse.
- loaduse: PC_Enable=0, IFID_Enable=0, IDEX_Flush=1, others enabled. Single cycle, no state change.
- StallCycles: increments every non-reset cycle with PC_Enable=0; saturates at all-ones.
- Wait counter:
  - Increments while memwait; clears when memwait=0.
  - When it reaches MEM_TIMEOUT, MemTimeout sets and stays set until reset.
  - Stalling continues regardless of MemTimeout.
- Reset mid-operation: synchronous reset overrides everything; next cycle State=RUN, counters 0.

Test Plan:
- Reset held 2 cycles, then released with no events: while reset, all enables 0 and flushes 0. After release, State=0, StallCycles=0, all enables 1.
- Load-use, rs match:
  - IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle -> PC_Enable=0, IFID_Enable=0, IDEX_Flush=1 that cycle; StallCycles=1.
  - Repeat with IDEX_Rt=0 -> no stall.
  - Repeat with IFID_Rt=8 and IFID_UsesRt=0 -> no stall.
- Mul/div, MULDIV_CYCLES=4: IDEX_MulDiv=1 held -> 3 consecutive cycles with PC_Enable=0 and EXMEM_Flush=1, State=1 on cycles 2-3, 4th cycle all enables 1. Final StallCycles=3, State=0.
- BranchTaken_EX=1 together with a load-use match -> PC_Enable=1, IFID_Flush=1, IDEX_Flush=1, IFID_Enable=1; StallCycles unchanged.
- Memwait inside mul/div:
  - EXMEM_MemAccess=1, MemReady=0 for 3 cycles while MULDIV counter=2 -> all upstream enables 0, MEMWB_Flush=1, counter held at 2. Mul/div completes 2 cycles after MemReady returns.
  - With MEM_TIMEOUT=16, MemReady low 16 cycles -> MemTimeout=1, still 1 after MemReady=1, cleared only by reset.
- Reset asserted on the second MULDIV cycle -> next cycle State=0, counter=0, StallCycles=0. A new IDEX_MulDiv=1 then retriggers a full 3-cycle stall.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Purpose : central hazard/stall sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB controls).
// Latency : control outputs are combinational from state, counters and inputs (zero cycles); statistics update on the next edge.
// Backpr. : data-memory wait freezes everything upstream of MEM/WB; mul/div occupancy freezes PC..ID/EX and bubbles EX/MEM.
//
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_IFID_*                : register specifiers of the instruction in ID
//   i_IDEX_*                : load / mul-div info of the instruction in EX
//   i_BranchTaken_EX        : branch in EX resolved taken
//   i_EXMEM_MemAccess       : MEM-stage instruction touches data memory
//   i_MemReady              : data memory ready this cycle
//   o_*_Enable / o_*_Flush  : pipeline register load enables and bubble inserts
//   o_MemTimeout            : sticky flag, memory wait exceeded MEM_TIMEOUT cycles
//   o_StallCycles           : saturating count of cycles with the PC frozen
//   o_State                 : 0 = RUN, 1 = MULDIV
module pipeline_stall_controller #(
    parameter int REG_BITS      = 5,
    parameter int MULDIV_CYCLES = 4,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_W         = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [REG_BITS-1:0] i_IFID_Rs,
    input  logic [REG_BITS-1:0] i_IFID_Rt,
    input  logic                i_IFID_UsesRt,
    input  logic                i_IDEX_MemRead,
    input  logic [REG_BITS-1:0] i_IDEX_Rt,
    input  logic                i_IDEX_MulDiv,
    input  logic                i_BranchTaken_EX,
    input  logic                i_EXMEM_MemAccess,
    input  logic                i_MemReady,
    output logic                o_PC_Enable,
    output logic                o_IFID_Enable,
    output logic                o_IFID_Flush,
    output logic                o_IDEX_Enable,
    output logic                o_IDEX_Flush,
    output logic                o_EXMEM_Enable,
    output logic                o_EXMEM_Flush,
    output logic                o_MEMWB_Enable,
    output logic                o_MEMWB_Flush,
    output logic                o_MemTimeout,
    output logic [CNT_W-1:0]    o_StallCycles,
    output logic                o_State
);

    // Counter widths: the mul/div counter only ever holds MULDIV_CYCLES-1 down to 0,
    // the wait counter saturates at MEM_TIMEOUT.
    localparam int MD_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [MD_W-1:0]  MD_LOAD  = MD_W'(MULDIV_CYCLES - 1);
    localparam logic [MD_W-1:0]  MD_ONE   = MD_W'(1);
    localparam logic [WT_W-1:0]  WT_MAX   = WT_W'(MEM_TIMEOUT);
    localparam logic [WT_W-1:0]  WT_ONE   = WT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               MD_STALL = (MULDIV_CYCLES > 1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [MD_W-1:0]  r_md_cnt;
    logic [WT_W-1:0]  r_wait_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state_nxt;
    logic [MD_W-1:0]  w_md_cnt_nxt;
    logic [WT_W-1:0]  w_wait_cnt_nxt;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;

    // ------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------
    logic w_memwait;
    logic w_loaduse;
    logic w_md_trigger;
    logic w_md_busy;
    logic w_md_release;
    logic w_md_stall;

    assign w_memwait = i_EXMEM_MemAccess & ~i_MemReady;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_loaduse = i_IDEX_MemRead && (i_IDEX_Rt != '0) &&
                       ((i_IFID_Rs == i_IDEX_Rt) ||
                        (i_IFID_UsesRt && (i_IFID_Rt == i_IDEX_Rt)));

    // Only RUN can start a mul/div; in the release cycle the same op is still
    // sitting in ID/EX, so IDEX_MulDiv must not start it again.
    assign w_md_trigger = MD_STALL && (r_state == ST_RUN) && i_IDEX_MulDiv;
    assign w_md_busy    = (r_state == ST_MULDIV) && (r_md_cnt > MD_ONE);
    assign w_md_release = (r_state == ST_MULDIV) && (r_md_cnt == MD_ONE);
    assign w_md_stall   = w_md_trigger || w_md_busy;

    // ------------------------------------------------------------------
    // Pipeline control outputs (priority: reset > memwait > mul/div > branch > loaduse)
    // ------------------------------------------------------------------
    always_comb begin
        o_PC_Enable    = 1'b1;
        o_IFID_Enable  = 1'b1;
        o_IFID_Flush   = 1'b0;
        o_IDEX_Enable  = 1'b1;
        o_IDEX_Flush   = 1'b0;
        o_EXMEM_Enable = 1'b1;
        o_EXMEM_Flush  = 1'b0;
        o_MEMWB_Enable = 1'b1;
        o_MEMWB_Flush  = 1'b0;

        if (i_reset) begin
            o_PC_Enable    = 1'b0;
            o_IFID_Enable  = 1'b0;
            o_IDEX_Enable  = 1'b0;
            o_EXMEM_Enable = 1'b0;
            o_MEMWB_Enable = 1'b0;
        end else if (w_memwait) begin
            // MEM holds its access; WB receives a bubble so the stalled
            // instruction is not written back twice.
            o_PC_Enable    = 1'b0;
            o_IFID_Enable  = 1'b0;
            o_IDEX_Enable  = 1'b0;
            o_EXMEM_Enable = 1'b0;
            o_MEMWB_Flush  = 1'b1;
        end else if (w_md_stall) begin
            // EX is occupied: hold everything behind it, bubble into MEM.
            o_PC_Enable    = 1'b0;
            o_IFID_Enable  = 1'b0;
            o_IDEX_Enable  = 1'b0;
            o_EXMEM_Flush  = 1'b1;
        end else if (i_BranchTaken_EX) begin
            // Squash the two wrong-path instructions; any load-use hazard
            // involves a squashed instruction and is therefore irrelevant.
            o_IFID_Flush   = 1'b1;
            o_IDEX_Flush   = 1'b1;
        end else if (w_loaduse) begin
            o_PC_Enable    = 1'b0;
            o_IFID_Enable  = 1'b0;
            o_IDEX_Flush   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_md_cnt_nxt    = r_md_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_timeout_nxt   = r_timeout;
        w_stall_cnt_nxt = r_stall_cnt;

        if (i_reset) begin
            w_state_nxt     = ST_RUN;
            w_md_cnt_nxt    = '0;
            w_wait_cnt_nxt  = '0;
            w_timeout_nxt   = 1'b0;
            w_stall_cnt_nxt = '0;
        end else begin
            // Mul/div sequencing is frozen while memory is waiting.
            if (!w_memwait) begin
                if (w_md_trigger) begin
                    w_state_nxt  = ST_MULDIV;
                    w_md_cnt_nxt = MD_LOAD;
                end else if (w_md_busy) begin
                    w_md_cnt_nxt = r_md_cnt - MD_ONE;
                end else if (w_md_release) begin
                    w_state_nxt  = ST_RUN;
                    w_md_cnt_nxt = '0;
                end
            end

            // Consecutive memwait cycles, saturating at the timeout threshold.
            if (w_memwait) begin
                if (r_wait_cnt != WT_MAX) begin
                    w_wait_cnt_nxt = r_wait_cnt + WT_ONE;
                end
            end else begin
                w_wait_cnt_nxt = '0;
            end

            if (w_wait_cnt_nxt == WT_MAX) begin
                w_timeout_nxt = 1'b1;
            end

            if (!o_PC_Enable && (r_stall_cnt != '1)) begin
                w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers (reset handled in the next-state logic, sampled here)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_md_cnt    <= '0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_md_cnt    <= w_md_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign o_MemTimeout  = r_timeout;
    assign o_StallCycles = r_stall_cnt;
    assign o_State       = (r_state == ST_MULDIV);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Purpose : directed-vector bench for pipeline_stall_controller with a queue-based scoreboard.
// Latency : each vector's expected outputs are checked mid-cycle of the cycle it is applied.
// Backpr. : none; the monitor drains one expectation per cycle.
module tb_pipeline_stall_controller;

    logic        clk;
    logic        reset;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        ifid_usesrt, idex_memread, idex_muldiv, br_taken, mem_access, mem_ready;
    logic        pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    logic        state;

    pipeline_stall_controller #(
        .REG_BITS(5), .MULDIV_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(16)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_IFID_Rs        (ifid_rs),
        .i_IFID_Rt        (ifid_rt),
        .i_IFID_UsesRt    (ifid_usesrt),
        .i_IDEX_MemRead   (idex_memread),
        .i_IDEX_Rt        (idex_rt),
        .i_IDEX_MulDiv    (idex_muldiv),
        .i_BranchTaken_EX (br_taken),
        .i_EXMEM_MemAccess(mem_access),
        .i_MemReady       (mem_ready),
        .o_PC_Enable      (pc_en),
        .o_IFID_Enable    (ifid_en),
        .o_IFID_Flush     (ifid_fl),
        .o_IDEX_Enable    (idex_en),
        .o_IDEX_Flush     (idex_fl),
        .o_EXMEM_Enable   (exmem_en),
        .o_EXMEM_Flush    (exmem_fl),
        .o_MEMWB_Enable   (memwb_en),
        .o_MEMWB_Flush    (memwb_fl),
        .o_MemTimeout     (mem_timeout),
        .o_StallCycles    (stall_cycles),
        .o_State          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word order: {PC_En, IFID_En, IFID_Fl, IDEX_En, IDEX_Fl, EXMEM_En, EXMEM_Fl, MEMWB_En, MEMWB_Fl}
    localparam logic [8:0] C_RST = 9'b000000000;
    localparam logic [8:0] C_RUN = 9'b110101010;
    localparam logic [8:0] C_LU  = 9'b000111010;
    localparam logic [8:0] C_MD  = 9'b000001110;
    localparam logic [8:0] C_BR  = 9'b111111010;
    localparam logic [8:0] C_MW  = 9'b000000011;

    typedef struct {
        string       nm;
        logic [8:0]  ctl;
        logic        to;
        logic [15:0] sc;
        logic        st;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [26:0] act, req;
            e   = q.pop_front();
            act = {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl,
                   mem_timeout, stall_cycles, state};
            req = {e.ctl, e.to, e.sc, e.st};
            n_vec++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b to=%b sc=%0d st=%b, expected ctl=%b to=%b sc=%0d st=%b",
                         e.nm, act[26:18], act[17], act[16:1], act[0],
                         e.ctl, e.to, e.sc, e.st);
            end
        end
    end

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic mr, input logic [4:0] xrt, input logic md, input logic br,
                         input logic ma, input logic rdy);
        reset        = rst;
        ifid_rs      = rs;
        ifid_rt      = rt;
        ifid_usesrt  = ur;
        idex_memread = mr;
        idex_rt      = xrt;
        idex_muldiv  = md;
        br_taken     = br;
        mem_access   = ma;
        mem_ready    = rdy;
    endtask

    task automatic expect_and_step(input string nm, input logic [8:0] ctl, input logic to,
                                   input int sc, input logic st);
        exp_t e;
        e.nm  = nm;
        e.ctl = ctl;
        e.to  = to;
        e.sc  = 16'(sc);
        e.st  = st;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [8:0] ctl, input logic to, input int sc, input logic st);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_and_step(nm, ctl, to, sc, st);
    endtask

    initial begin
        // First reset cycle: registers not yet initialised, left unchecked.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        expect_and_step("reset_hold", C_RST, 0, 0, 0);
        idle("run_after_reset", C_RUN, 0, 0, 0);

        // Load-use hazards
        drive(0, 8, 0, 0, 1, 8, 0, 0, 0, 1);
        expect_and_step("loaduse_rs", C_LU, 0, 0, 0);
        idle("after_loaduse", C_RUN, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        expect_and_step("loaduse_r0", C_RUN, 0, 1, 0);
        drive(0, 3, 8, 0, 1, 8, 0, 0, 0, 1);
        expect_and_step("loaduse_rt_unused", C_RUN, 0, 1, 0);
        drive(0, 3, 8, 1, 1, 8, 0, 0, 0, 1);
        expect_and_step("loaduse_rt_used", C_LU, 0, 1, 0);

        // Mul/div: 3 stall cycles then release
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        expect_and_step("md_trigger", C_MD, 0, 2, 0);
        expect_and_step("md_busy1", C_MD, 0, 3, 1);
        expect_and_step("md_busy2", C_MD, 0, 4, 1);
        expect_and_step("md_release", C_RUN, 0, 5, 1);
        idle("md_done", C_RUN, 0, 5, 0);

        // Branch beats load-use
        drive(0, 8, 0, 0, 1, 8, 0, 1, 0, 1);
        expect_and_step("branch_over_lu", C_BR, 0, 5, 0);
        idle("after_branch", C_RUN, 0, 5, 0);

        // Memwait while the mul/div counter is at 2
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        expect_and_step("md2_trigger", C_MD, 0, 5, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_and_step("md2_busy1", C_MD, 0, 6, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            expect_and_step($sformatf("md_memwait%0d", i), C_MW, 0, 7 + i, 1);
        end
        idle("md2_resume", C_MD, 0, 10, 1);
        idle("md2_release", C_RUN, 0, 11, 1);
        idle("md2_done", C_RUN, 0, 11, 0);

        // Memory timeout: 16 wait cycles, flag visible from the 17th
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            expect_and_step($sformatf("memwait%0d", i), C_MW, 0, 11 + i, 0);
        end
        idle("timeout_set", C_RUN, 1, 27, 0);
        idle("timeout_sticky", C_RUN, 1, 27, 0);

        // Reset in the second MULDIV cycle, then a full retrigger
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        expect_and_step("md3_trigger", C_MD, 1, 27, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        expect_and_step("md3_reset", C_RST, 1, 28, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        expect_and_step("md4_trigger", C_MD, 0, 0, 0);
        expect_and_step("md4_busy1", C_MD, 0, 1, 1);
        expect_and_step("md4_busy2", C_MD, 0, 2, 1);
        idle("md4_release", C_RUN, 0, 3, 1);
        idle("md4_done", C_RUN, 0, 3, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
